packet_tx: RTL and testbench

PACKET_TX -- requirements
Module: packet_tx

---
 rtl/packet_pkg.sv | 15 +
 rtl/packet_parity_gen.sv | 13 +
 rtl/packet_tx.sv | 134 +++++++++++++
 tb/tb_packet_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// Shared packet framing constants and transmit/receive FSM state encoding.
package packet_pkg;

  localparam int unsigned PACKET_SIZE = 64;
  localparam int unsigned SYNC_LSB    = 10;
  localparam int unsigned SYNC_WIDTH  = 4;
  localparam int unsigned GAP_BITS    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/packet_parity_gen.sv
// XOR-reduction of a packet word, used to build the even-parity bit.
module packet_parity_gen
  import packet_pkg::*;
#(
  parameter int unsigned WIDTH = PACKET_SIZE
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_c
);

  assign parity_c = ^data_i;

endmodule

// File: rtl/packet_tx.sv
// Serial packet transmitter: MSB-first shift-out with sync field and idle gap.
// Define PACKET_TX_PARITY_EN to replace bit 0 with an even-parity bit.
module packet_tx #(
  parameter int unsigned PACKET_SIZE = packet_pkg::PACKET_SIZE,
  parameter int unsigned SYNC_LSB    = packet_pkg::SYNC_LSB,
  parameter int unsigned SYNC_WIDTH  = packet_pkg::SYNC_WIDTH,
  parameter int unsigned GAP_BITS    = packet_pkg::GAP_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PACKET_SIZE-1:0] pkt_data,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  input  logic                   en,
  input  logic                   pkt_abort,
  output logic                   dout,
  output logic                   busy,
  output logic                   pkt_done
);
  import packet_pkg::*;

  localparam int unsigned CNT_W = $clog2(PACKET_SIZE + 1);
  localparam int unsigned GAP_W = $clog2(GAP_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PACKET_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PACKET_SIZE);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [PACKET_SIZE-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   dout_q, dout_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [PACKET_SIZE-1:0] sync_word;
  logic [PACKET_SIZE-1:0] load_word;

  // Sync field is always forced high in the transmitted word.
  always_comb begin
    sync_word = pkt_data;
    sync_word[SYNC_LSB +: SYNC_WIDTH] = '1;
  end

`ifdef PACKET_TX_PARITY_EN
  logic parity_c;

  packet_parity_gen #(
    .WIDTH (PACKET_SIZE)
  ) u_parity (
    .data_i   (sync_word),
    .parity_c (parity_c)
  );

  // Full-word XOR with bit 0 folded back out gives the parity of [MSB:1].
  always_comb begin
    load_word    = sync_word;
    load_word[0] = parity_c ^ sync_word[0];
  end
`else
  assign load_word = sync_word;
`endif

  // Next-state and registered-output logic; reset and abort dominate.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    done_d  = 1'b0;

    if (rst || pkt_abort) begin
      state_d = ST_IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pkt_valid) begin
            shreg_d = load_word;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (en) begin
            shreg_d = {shreg_q[PACKET_SIZE-2:0], 1'b0};
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_q == LAST_BIT) begin
              state_d = ST_GAP;
              gap_d   = '0;
              done_d  = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (en) begin
            if (gap_q == LAST_GAP) begin
              state_d = ST_IDLE;
              gap_d   = '0;
            end else begin
              gap_d = gap_q + GAP_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    dout_d = (state_d == ST_SHIFT) ? shreg_d[PACKET_SIZE-1] : 1'b0;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    shreg_q <= shreg_d;
    cnt_q   <= cnt_d;
    gap_q   <= gap_d;
    dout_q  <= dout_d;
    busy_q  <= busy_d;
    done_q  <= done_d;
  end

  assign pkt_ready = (state_q == ST_IDLE) && !rst;
  assign dout      = dout_q;
  assign busy      = busy_q;
  assign pkt_done  = done_q;

endmodule

// File: tb/tb_packet_tx.sv
// Randomized self-checking bench for packet_tx against a queue-based bit-slot model.
module tb_packet_tx;
  import packet_pkg::*;

  localparam int unsigned PS = PACKET_SIZE;
  localparam int unsigned GB = GAP_BITS;

  logic          clk = 1'b0;
  logic          rst;
  logic [PS-1:0] pkt_data;
  logic          pkt_valid;
  logic          pkt_ready;
  logic          en;
  logic          pkt_abort;
  logic          dout;
  logic          busy;
  logic          pkt_done;

  always #5 clk = ~clk;

  packet_tx dut (
    .clk       (clk),
    .rst       (rst),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .en        (en),
    .pkt_abort (pkt_abort),
    .dout      (dout),
    .busy      (busy),
    .pkt_done  (pkt_done)
  );

  // Model: remaining bits of the packet in flight, idle slots left, done flag.
  bit exp_bits[$];
  int gap_left;
  bit exp_done;
  int n_cmp;
  int n_err;
  int cyc;

  function automatic logic [PS-1:0] tx_word(input logic [PS-1:0] d);
    logic [PS-1:0] w;
    w = d;
    for (int i = 0; i < int'(SYNC_WIDTH); i++) w[SYNC_LSB + i] = 1'b1;
`ifdef PACKET_TX_PARITY_EN
    begin
      logic p;
      p = 1'b0;
      for (int i = 1; i < int'(PS); i++) p = p ^ w[i];
      w[0] = p;
    end
`endif
    return w;
  endfunction

  task automatic model_step();
    logic [PS-1:0] w;
    if (rst || pkt_abort) begin
      exp_bits.delete();
      gap_left = 0;
      exp_done = 1'b0;
    end else if (exp_bits.size() > 0) begin
      exp_done = 1'b0;
      if (en) begin
        void'(exp_bits.pop_front());
        if (exp_bits.size() == 0) begin
          gap_left = GB;
          exp_done = 1'b1;
        end
      end
    end else if (gap_left > 0) begin
      exp_done = 1'b0;
      if (en) gap_left--;
    end else begin
      exp_done = 1'b0;
      if (pkt_valid) begin
        w = tx_word(pkt_data);
        for (int i = int'(PS) - 1; i >= 0; i--) exp_bits.push_back(w[i]);
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock: advance the model with the applied inputs, then compare at negedge.
  task automatic tick();
    bit  e_dout;
    bit  e_busy;
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e_dout = (exp_bits.size() > 0) ? exp_bits[0] : 1'b0;
    e_busy = (exp_bits.size() > 0) || (gap_left > 0);
    check("dout",      64'(dout),      64'(e_dout));
    check("busy",      64'(busy),      64'(e_busy));
    check("pkt_done",  64'(pkt_done),  64'(exp_done));
    check("pkt_ready", 64'(pkt_ready), 64'(!e_busy && !rst));
  endtask

  // Load one word, send it with en high every 'period' cycles, then run the gap.
  task automatic run_pkt(input logic [PS-1:0] d, input logic [PS-1:0] d_next,
                         input bit hold, input int period,
                         output logic [PS-1:0] word, output int shift_cycles,
                         output int dones, output int gap_busy);
    pkt_data  = d;
    pkt_valid = 1'b1;
    en        = 1'b0;
    tick();
    pkt_valid = hold;
    pkt_data  = d_next;
    shift_cycles = 0;
    dones        = 0;
    gap_busy     = 0;
    word         = '0;
    for (int i = 0; i < int'(PS); i++) begin
      word[int'(PS) - 1 - i] = dout;
      for (int k = 0; k < period - 1; k++) begin
        en = 1'b0;
        tick();
        shift_cycles++;
      end
      en = 1'b1;
      tick();
      shift_cycles++;
      dones += int'(pkt_done);
    end
    for (int g = 0; g < int'(GB); g++) begin
      gap_busy += int'(busy);
      en = 1'b1;
      tick();
      dones += int'(pkt_done);
    end
    en = 1'b0;
  endtask

  initial begin
    logic [PS-1:0] word;
    logic [PS-1:0] d;
    int            sc;
    int            dn;
    int            gb;
    int            acc;

    n_cmp = 0; n_err = 0; cyc = 0;
    gap_left = 0; exp_done = 1'b0;
    rst = 1'b1; pkt_valid = 1'b1; pkt_abort = 1'b1; en = 1'b1;
    pkt_data = '1;

    // Reset overrides valid/abort/en.
    tick();
    tick();
    check("rst_dout",  64'(dout),      64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_done",  64'(pkt_done),  64'd0);
    check("rst_ready", 64'(pkt_ready), 64'd0);
    rst = 1'b0; pkt_valid = 1'b0; pkt_abort = 1'b0; en = 1'b0;
    tick();
    check("ready_after_rst", 64'(pkt_ready), 64'd1);

    // All-zero word: only the sync field is set.
    run_pkt('0, '0, 1'b0, 1, word, sc, dn, gb);
    check("zero_word",     64'(word), 64'h3C00);
    check("zero_dones",    64'(dn),   64'd1);
    check("zero_gap_busy", 64'(gb),   64'(GB));
    check("zero_idle",     64'(busy), 64'd0);

    // Bit 0 handling with and without parity.
    run_pkt(PS'(64'h1), '0, 1'b0, 1, word, sc, dn, gb);
`ifdef PACKET_TX_PARITY_EN
    check("one_word", 64'(word), 64'h3C00);
`else
    check("one_word", 64'(word), 64'h3C01);
`endif

    // en gated 1-in-3.
    d = PS'({$urandom(), $urandom()});
    run_pkt(d, '0, 1'b0, 3, word, sc, dn, gb);
    check("gated_cycles", 64'(sc),   64'(3 * PS));
    check("gated_word",   64'(word), 64'(tx_word(d)));
    check("gated_dones",  64'(dn),   64'd1);

    // Reset mid-packet after bit 20.
    pkt_data = '1; pkt_valid = 1'b1; tick();
    pkt_valid = 1'b0; en = 1'b1;
    repeat (20) tick();
    rst = 1'b1; en = 1'b0;
    tick();
    check("midrst_dout", 64'(dout),     64'd0);
    check("midrst_busy", 64'(busy),     64'd0);
    check("midrst_done", 64'(pkt_done), 64'd0);
    rst = 1'b0;
    tick();
    check("midrst_ready", 64'(pkt_ready), 64'd1);
    en = 1'b1; acc = 0;
    repeat (6) begin tick(); acc += int'(dout) + int'(pkt_done) + int'(busy); end
    check("midrst_residue", 64'(acc), 64'd0);
    en = 1'b0;

    // Abort beats a same-cycle load.
    pkt_data = '1; pkt_valid = 1'b1; pkt_abort = 1'b1;
    tick();
    check("abort_noload", 64'(busy), 64'd0);
    pkt_abort = 1'b0;

    // Valid held through a packet: second word waits for the gap to finish.
    run_pkt(PS'(64'h8000_0000_0000_0000), PS'(64'hC000_0000_0000_0000), 1'b1, 1,
            word, sc, dn, gb);
`ifdef PACKET_TX_PARITY_EN
    check("held_word", 64'(word), 64'h8000_0000_0000_3C01);
`else
    check("held_word", 64'(word), 64'h8000_0000_0000_3C00);
`endif
    check("held_gap_busy", 64'(gb),   64'(GB));
    check("held_idle",     64'(busy), 64'd0);
    tick();
    check("second_msb", 64'(dout), 64'd1);
    check("second_busy", 64'(busy), 64'd1);
    pkt_valid = 1'b0; pkt_abort = 1'b1;
    tick();
    check("abort_shift", 64'(busy), 64'd0);
    pkt_abort = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 6000; n++) begin
      pkt_data  = PS'({$urandom(), $urandom()});
      pkt_valid = ($urandom_range(0, 2) == 0);
      en        = ($urandom_range(0, 3) != 0);
      pkt_abort = ($urandom_range(0, 299) == 0);
      rst       = ($urandom_range(0, 699) == 0);
      tick();
    end
    rst = 1'b0; pkt_abort = 1'b0; pkt_valid = 1'b0; en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
